delay_sched: RTL

DELAY_SCHED -- requirements
Module: delay_sched

---
 rtl/delay_pkg.sv | 5 +
 rtl/delay_sched_rr_arbiter.sv | 29 ++
 rtl/delay_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/delay_pkg.sv
// delay_pkg: shared FSM states and level width for the delay-line scheduler
package delay_pkg;
  localparam int DLY_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SETTLE, S_DWELL, S_RESTORE} state_t;
endpackage

// File: rtl/delay_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot selector; search starts one past the last winner
// ports: req requests, upd advances the pointer past idx, sel/idx/any describe the winner
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  output logic [NREQ-1:0] sel,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [IW-1:0] ptr;
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) begin
        idx = IW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    sel = NREQ'(any) << idx;
  end
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (upd) ptr <= IW'((int'(idx) + 1) % NREQ);
endmodule

// File: rtl/delay_sched.sv
// delay_sched: arbitrates requester levels onto a shared programmable delay line
// ports: req/req_lvl requests in, gnt grant pulse, wr_comm/upr delay-line write,
// cur_lvl last written level, busy/settled status, err_range clamp pulse,
// sweep_start/sweep_done level sweep (compiled in only with DELAY_SWEEP_EN)
module delay_sched import delay_pkg::*; #(
  parameter int NREQ   = 4,
  parameter int SIZE   = 20,
  parameter int SETTLE = 2,
  parameter int DWELL  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DLY_W-1:0] req_lvl,
  input  logic                  sweep_start,
  output logic [NREQ-1:0]       gnt,
  output logic                  wr_comm,
  output logic [DLY_W-1:0]      upr,
  output logic [DLY_W-1:0]      cur_lvl,
  output logic                  busy,
  output logic                  settled,
  output logic                  err_range,
  output logic                  sweep_done
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t            state;
  logic [15:0]       cnt;
  logic [NREQ-1:0]   arb_sel;
  logic [IW-1:0]     idx;
  logic              any, over, skip, upd;
  logic [DLY_W-1:0]  lvl_raw, lvl;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req),
    .upd(upd),
    .sel(arb_sel),
    .idx(idx),
    .any(any)
  );
  assign lvl_raw = req_lvl[idx*DLY_W +: DLY_W];
  assign over    = int'(lvl_raw) >= SIZE;
  assign lvl     = over ? DLY_W'(SIZE - 1) : lvl_raw;
  // the line already sits at this level, so grant without rewriting it
  assign skip    = lvl == cur_lvl && settled;
`ifdef DELAY_SWEEP_EN
  logic             sweeping, restoring;
  logic [DLY_W-1:0] sw_lvl, saved;
  assign upd = state == S_IDLE && any && !sweep_start;
`else
  logic unused_cfg;
  assign unused_cfg = sweep_start ^ (DWELL == 0);
  assign upd        = state == S_IDLE && any;
  assign sweep_done = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_comm   <= 1'b0;
      upr       <= '0;
      cur_lvl   <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      settled   <= 1'b0;
      err_range <= 1'b0;
`ifdef DELAY_SWEEP_EN
      sweep_done <= 1'b0;
      sweeping   <= 1'b0;
      restoring  <= 1'b0;
      sw_lvl     <= '0;
      saved      <= '0;
`endif
    end else begin
      wr_comm   <= 1'b0;
      gnt       <= '0;
      err_range <= 1'b0;
`ifdef DELAY_SWEEP_EN
      sweep_done <= 1'b0;
`endif
      case (state)
        S_IDLE:
`ifdef DELAY_SWEEP_EN
          if (sweep_start) begin
            state    <= S_WRITE;
            wr_comm  <= 1'b1;
            upr      <= '0;
            cur_lvl  <= '0;
            busy     <= 1'b1;
            settled  <= 1'b0;
            sweeping <= 1'b1;
            sw_lvl   <= '0;
            saved    <= cur_lvl;
          end else
`endif
          if (any) begin
            gnt       <= arb_sel;
            err_range <= over;
            if (!skip) begin
              state   <= S_WRITE;
              wr_comm <= 1'b1;
              upr     <= lvl;
              cur_lvl <= lvl;
              busy    <= 1'b1;
              settled <= 1'b0;
            end
          end
        S_WRITE, S_RESTORE: begin
          state <= S_SETTLE;
          cnt   <= '0;
        end
        S_SETTLE:
          if (cnt == 16'(SETTLE - 1)) begin
            cnt     <= '0;
            settled <= 1'b1;
`ifdef DELAY_SWEEP_EN
            if (sweeping && !restoring) state <= S_DWELL;
            else begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              sweep_done <= restoring;
              sweeping   <= 1'b0;
              restoring  <= 1'b0;
            end
`else
            state <= S_IDLE;
            busy  <= 1'b0;
`endif
          end else cnt <= cnt + 16'd1;
`ifdef DELAY_SWEEP_EN
        S_DWELL:
          if (cnt == 16'(DWELL - 1)) begin
            cnt     <= '0;
            wr_comm <= 1'b1;
            settled <= 1'b0;
            if (sw_lvl == DLY_W'(SIZE - 1)) begin
              state     <= S_RESTORE;
              restoring <= 1'b1;
              upr       <= saved;
              cur_lvl   <= saved;
            end else begin
              state   <= S_WRITE;
              upr     <= sw_lvl + 8'd1;
              cur_lvl <= sw_lvl + 8'd1;
              sw_lvl  <= sw_lvl + 8'd1;
            end
          end else cnt <= cnt + 16'd1;
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule
